engine_read_arbiter: RTL and testbench

//  Parametrised multi-engine DRAM read arbiter; shares one AXI read port among NUM_ENGINES Smith-Waterman engines.

---
 rtl/engine_read_arbiter.sv | 195 +++++++++++++++++++
 tb/tb_engine_read_arbiter.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/engine_read_arbiter.sv
// rtl/engine_read_arbiter.sv - round-robin multi-engine DRAM read arbiter with ID-tagged beat return
// Optional per-engine grant counters are built when READ_ARB_PERF_EN is defined.
module engine_read_arbiter #(
    parameter int NUM_ENGINES         = 4,
    parameter int C0_C_S_AXI_ID_WIDTH = 8,
    parameter int DATA_W              = 256,
    parameter int MAX_OUTSTANDING     = 4
) (
    input  logic                                           clk,
    input  logic                                           rst,
    input  logic [NUM_ENGINES*(C0_C_S_AXI_ID_WIDTH-4)-1:0] eng_rd_id_in,
    input  logic [NUM_ENGINES*33-1:0]                      eng_rd_addr_in,
    input  logic [NUM_ENGINES*8-1:0]                       eng_rd_len_in,
    input  logic [NUM_ENGINES-1:0]                         eng_rd_info_valid_in,
    output logic [NUM_ENGINES-1:0]                         eng_rd_info_rdy_out,
    output logic [DATA_W-1:0]                              eng_rd_data_out,
    output logic [NUM_ENGINES-1:0]                         eng_rd_data_valid_out,
    input  logic [NUM_ENGINES-1:0]                         eng_rd_data_rdy_in,
    output logic [C0_C_S_AXI_ID_WIDTH-1:0]                 rd_id_out,
    output logic [32:0]                                    rd_addr_out,
    output logic [7:0]                                     rd_len_out,
    output logic                                           rd_info_valid_out,
    input  logic                                           rd_info_rdy_in,
    input  logic [DATA_W-1:0]                              rd_data_in,
    input  logic [C0_C_S_AXI_ID_WIDTH-1:0]                 rd_id_in,
    input  logic                                           rd_last_in,
    input  logic                                           rd_data_valid_in,
    output logic                                           rd_data_rdy_out,
    output logic                                           bad_id_out,
    input  logic [3:0]                                     perf_sel_in,
    output logic [31:0]                                    perf_cnt_out
);
    localparam int ID_W  = C0_C_S_AXI_ID_WIDTH;
    localparam int LID_W = ID_W - 4;
    localparam int PTR_W = (NUM_ENGINES > 1) ? $clog2(NUM_ENGINES) : 1;

    typedef enum logic [0:0] {IDLE, REQ} state_t;
    state_t state, state_next;

    logic [PTR_W-1:0]       rr_ptr, grant, grant_q;
    logic                   found;
    logic [3:0]             outstanding [NUM_ENGINES];
    logic [NUM_ENGINES-1:0] eligible, cnt_inc, cnt_dec;
    logic [LID_W-1:0]       sel_lid;
    logic [32:0]            sel_addr;
    logic [7:0]             sel_len;
    logic [3:0]             sel;
    logic                   sel_ok, req_fire, beat_fire;

    function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] p, input int k);
        int s;
        s = int'(p) + k;
        if (s >= NUM_ENGINES) s = s - NUM_ENGINES;
        return PTR_W'(s);
    endfunction

    always_comb begin
        for (int e = 0; e < NUM_ENGINES; e++)
            eligible[e] = eng_rd_info_valid_in[e] && (outstanding[e] < 4'(MAX_OUTSTANDING));
    end

    // First eligible engine at or after rr_ptr; saturated engines are simply passed over.
    always_comb begin
        found = 1'b0;
        grant = rr_ptr;
        for (int k = 0; k < NUM_ENGINES; k++) begin
            if (!found && eligible[ptr_add(rr_ptr, k)]) begin
                found = 1'b1;
                grant = ptr_add(rr_ptr, k);
            end
        end
    end

    always_comb begin
        sel_lid  = '0;
        sel_addr = '0;
        sel_len  = '0;
        for (int e = 0; e < NUM_ENGINES; e++) begin
            if (grant == PTR_W'(e)) begin
                sel_lid  = eng_rd_id_in[e*LID_W +: LID_W];
                sel_addr = eng_rd_addr_in[e*33 +: 33];
                sel_len  = eng_rd_len_in[e*8 +: 8];
            end
        end
    end

    always_comb begin
        state_next          = state;
        eng_rd_info_rdy_out = '0;
        case (state)
            IDLE: begin
                if (found && !rst) begin
                    eng_rd_info_rdy_out[grant] = 1'b1;
                    state_next                 = REQ;
                end
            end
            REQ: begin
                if (rd_info_rdy_in) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign rd_info_valid_out = (state == REQ);
    assign req_fire          = (state == REQ) && rd_info_rdy_in;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            grant_q     <= '0;
            rd_id_out   <= '0;
            rd_addr_out <= '0;
            rd_len_out  <= '0;
        end else begin
            state <= state_next;
            if (state == IDLE && found) begin
                grant_q     <= grant;
                rd_id_out   <= {4'(grant), sel_lid};
                rd_addr_out <= sel_addr;
                rd_len_out  <= sel_len;
            end
            if (req_fire) rr_ptr <= ptr_add(grant_q, 1);
        end
    end

    // Beats are steered purely by the engine field of the returned ID; unknown engines are drained.
    assign sel             = rd_id_in[ID_W-1 -: 4];
    assign sel_ok          = (32'(sel) < NUM_ENGINES);
    assign eng_rd_data_out = rd_data_in;

    always_comb begin
        eng_rd_data_valid_out = '0;
        rd_data_rdy_out       = 1'b1;
        for (int e = 0; e < NUM_ENGINES; e++) begin
            if (sel == 4'(e)) begin
                eng_rd_data_valid_out[e] = rd_data_valid_in;
                rd_data_rdy_out          = eng_rd_data_rdy_in[e];
            end
        end
    end

    assign beat_fire = rd_data_valid_in && rd_data_rdy_out && rd_last_in;

    always_comb begin
        for (int e = 0; e < NUM_ENGINES; e++) begin
            cnt_inc[e] = req_fire && (grant_q == PTR_W'(e));
            cnt_dec[e] = beat_fire && (sel == 4'(e));
        end
    end

    // Decrement saturates at zero so stale last-beats after a reset cannot wrap the count.
    always_ff @(posedge clk) begin
        for (int e = 0; e < NUM_ENGINES; e++) begin
            if (rst)
                outstanding[e] <= '0;
            else if (cnt_inc[e] && !cnt_dec[e])
                outstanding[e] <= outstanding[e] + 4'd1;
            else if (cnt_dec[e] && !cnt_inc[e] && outstanding[e] != 4'd0)
                outstanding[e] <= outstanding[e] - 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            bad_id_out <= 1'b0;
        else if (rd_data_valid_in && !sel_ok)
            bad_id_out <= 1'b1;
    end

`ifdef READ_ARB_PERF_EN
    logic [31:0] perf_cnt [NUM_ENGINES];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int e = 0; e < NUM_ENGINES; e++) perf_cnt[e] <= '0;
            perf_cnt_out <= '0;
        end else begin
            for (int e = 0; e < NUM_ENGINES; e++)
                if (cnt_inc[e]) perf_cnt[e] <= perf_cnt[e] + 32'd1;
            perf_cnt_out <= '0;
            for (int e = 0; e < NUM_ENGINES; e++)
                if (perf_sel_in == 4'(e)) perf_cnt_out <= perf_cnt[e];
        end
    end
`else
    logic unused_perf_sel;
    assign unused_perf_sel = ^perf_sel_in;
    assign perf_cnt_out    = '0;
`endif

    logic unused_id_low;
    assign unused_id_low = ^rd_id_in[LID_W-1:0];

endmodule

// File: tb/tb_engine_read_arbiter.sv
// tb/tb_engine_read_arbiter.sv - scoreboard bench for engine_read_arbiter
module tb_engine_read_arbiter;
    localparam int NE = 4;
    localparam int IDW = 8;
    localparam int DW = 256;
    localparam int MO = 4;
    localparam int LW = IDW - 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [NE*LW-1:0]  eng_rd_id_in;
    logic [NE*33-1:0]  eng_rd_addr_in;
    logic [NE*8-1:0]   eng_rd_len_in;
    logic [NE-1:0]     eng_rd_info_valid_in;
    logic [NE-1:0]     eng_rd_info_rdy_out;
    logic [DW-1:0]     eng_rd_data_out;
    logic [NE-1:0]     eng_rd_data_valid_out;
    logic [NE-1:0]     eng_rd_data_rdy_in;
    logic [IDW-1:0]    rd_id_out;
    logic [32:0]       rd_addr_out;
    logic [7:0]        rd_len_out;
    logic              rd_info_valid_out;
    logic              rd_info_rdy_in;
    logic [DW-1:0]     rd_data_in;
    logic [IDW-1:0]    rd_id_in;
    logic              rd_last_in;
    logic              rd_data_valid_in;
    logic              rd_data_rdy_out;
    logic              bad_id_out;
    logic [3:0]        perf_sel_in;
    logic [31:0]       perf_cnt_out;

    engine_read_arbiter #(
        .NUM_ENGINES(NE), .C0_C_S_AXI_ID_WIDTH(IDW), .DATA_W(DW), .MAX_OUTSTANDING(MO)
    ) dut (
        .clk(clk), .rst(rst),
        .eng_rd_id_in(eng_rd_id_in), .eng_rd_addr_in(eng_rd_addr_in),
        .eng_rd_len_in(eng_rd_len_in), .eng_rd_info_valid_in(eng_rd_info_valid_in),
        .eng_rd_info_rdy_out(eng_rd_info_rdy_out), .eng_rd_data_out(eng_rd_data_out),
        .eng_rd_data_valid_out(eng_rd_data_valid_out), .eng_rd_data_rdy_in(eng_rd_data_rdy_in),
        .rd_id_out(rd_id_out), .rd_addr_out(rd_addr_out), .rd_len_out(rd_len_out),
        .rd_info_valid_out(rd_info_valid_out), .rd_info_rdy_in(rd_info_rdy_in),
        .rd_data_in(rd_data_in), .rd_id_in(rd_id_in), .rd_last_in(rd_last_in),
        .rd_data_valid_in(rd_data_valid_in), .rd_data_rdy_out(rd_data_rdy_out),
        .bad_id_out(bad_id_out), .perf_sel_in(perf_sel_in), .perf_cnt_out(perf_cnt_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          eng;
        logic [7:0]  id;
        logic [32:0] addr;
        logic [7:0]  len;
    } req_t;

    req_t req_q[$];
    int   grant_exp[$];
    int   left[NE];
    int   seq[NE];
    int   gcount[NE];
    int   hs_count[NE];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic req_t make_req(input int e, input int s);
        req_t r;
        r.eng  = e;
        r.id   = {4'(e), 4'(s)};
        r.addr = 33'h1_0000_0000 | (33'(e) << 20) | (33'(s) << 6);
        r.len  = 8'(e * 16 + s + 1);
        return r;
    endfunction

    task automatic drive_engines();
        req_t r;
        for (int e = 0; e < NE; e++) begin
            r = make_req(e, seq[e]);
            eng_rd_info_valid_in[e]    = (left[e] > 0);
            eng_rd_id_in[e*LW +: LW]   = r.id[LW-1:0];
            eng_rd_addr_in[e*33 +: 33] = r.addr;
            eng_rd_len_in[e*8 +: 8]    = r.len;
        end
    endtask

    // Negedge: record engine acceptances into the scoreboard, pop it on AXI handshakes.
    task automatic sample();
        req_t r;
        @(negedge clk);
        if ($countones(eng_rd_info_rdy_out) > 1)
            check("rdy_onehot", 64'($countones(eng_rd_info_rdy_out)), 64'd1);
        if ((eng_rd_info_rdy_out & ~eng_rd_info_valid_in) != '0)
            check("rdy_without_valid", 64'(eng_rd_info_rdy_out), 64'(eng_rd_info_rdy_out & eng_rd_info_valid_in));
        for (int e = 0; e < NE; e++) begin
            if (eng_rd_info_valid_in[e] && eng_rd_info_rdy_out[e]) begin
                if (grant_exp.size() > 0) check("grant_order", 64'(e), 64'(grant_exp.pop_front()));
                req_q.push_back(make_req(e, seq[e]));
                seq[e]++;
                left[e]--;
                gcount[e]++;
            end
        end
        if (rd_info_valid_out && rd_info_rdy_in && !rst) begin
            if (req_q.size() == 0) begin
                check("axi_unexpected", 64'd1, 64'd0);
            end else begin
                r = req_q.pop_front();
                check("axi_id", 64'(rd_id_out), 64'(r.id));
                check("axi_addr", 64'(rd_addr_out), 64'(r.addr));
                check("axi_len", 64'(rd_len_out), 64'(r.len));
                hs_count[r.eng]++;
            end
        end
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
        drive_engines();
    endtask

    task automatic tick();
        sample();
        advance();
    endtask

    function automatic int busy_now();
        int b;
        b = 0;
        for (int e = 0; e < NE; e++) if (left[e] > 0) b = 1;
        if (req_q.size() > 0 || rd_info_valid_out) b = 1;
        return b;
    endfunction

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 60; i++) begin
            if (busy_now() == 0) break;
            tick();
        end
        check({tag, "_idle"}, 64'(busy_now()), 64'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) advance();
        rst = 1'b0;
        req_q.delete();
        for (int e = 0; e < NE; e++) hs_count[e] = 0;
    endtask

    task automatic set_beat(input logic [7:0] id, input logic [NE-1:0] rdy);
        for (int i = 0; i < DW / 32; i++) rd_data_in[i*32 +: 32] = $urandom();
        rd_id_in           = id;
        rd_last_in         = 1'b1;
        rd_data_valid_in   = 1'b1;
        eng_rd_data_rdy_in = rdy;
    endtask

    task automatic clear_beat();
        rd_data_valid_in   = 1'b0;
        rd_last_in         = 1'b0;
        eng_rd_data_rdy_in = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int    b0, b1, b2;
        req_t  exp3;
        logic [63:0] exp_perf;

        rst = 1'b1;
        rd_info_rdy_in = 1'b0;
        rd_data_in = '0;
        rd_id_in = '0;
        perf_sel_in = 4'd0;
        clear_beat();
        for (int e = 0; e < NE; e++) begin
            left[e] = 0; seq[e] = 0; gcount[e] = 0; hs_count[e] = 0;
        end
        drive_engines();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_valid", 64'(rd_info_valid_out), 64'd0);
        check("rst_rdy", 64'(eng_rd_info_rdy_out), 64'd0);
        check("rst_id", 64'(rd_id_out), 64'd0);
        check("rst_addr", 64'(rd_addr_out), 64'd0);
        check("rst_len", 64'(rd_len_out), 64'd0);
        check("rst_bad", 64'(bad_id_out), 64'd0);
        check("rst_dvalid", 64'(eng_rd_data_valid_out), 64'd0);
        check("rst_perf", 64'(perf_cnt_out), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Round-robin across all engines, engine 0 asking twice.
        left[0] = 2; left[1] = 1; left[2] = 1; left[3] = 1;
        grant_exp = '{0, 1, 2, 3, 0};
        rd_info_rdy_in = 1'b1;
        drive_engines();
        wait_idle("t1");
        check("t1_grants", 64'(gcount[0] + gcount[1] + gcount[2] + gcount[3]), 64'd5);
        check("t1_order_consumed", 64'(grant_exp.size()), 64'd0);

        // Outstanding limit on engine 1, then release by a last beat.
        do_reset();
        b1 = gcount[1];
        b2 = gcount[2];
        left[1] = 5;
        drive_engines();
        repeat (12) tick();
        check("t2_limit", 64'(gcount[1] - b1), 64'd4);
        check("t2_axi_idle", 64'(rd_info_valid_out), 64'd0);
        left[2] = 1;
        drive_engines();
        repeat (4) tick();
        check("t2_e2_granted", 64'(gcount[2] - b2), 64'd1);
        check("t2_e1_held", 64'(gcount[1] - b1), 64'd4);
        set_beat(8'h10, 4'b0010);
        sample();
        check("t2_beat_valid", 64'(eng_rd_data_valid_out), 64'h2);
        check("t2_beat_rdy", 64'(rd_data_rdy_out), 64'd1);
        check("t2_still_blocked", 64'(eng_rd_info_rdy_out), 64'd0);
        advance();
        clear_beat();
        sample();
        check("t2_regrant", 64'(eng_rd_info_rdy_out), 64'h2);
        advance();
        wait_idle("t2");
        check("t2_total", 64'(gcount[1] - b1), 64'd5);

        // AXI back-pressure in REQ.
        b0 = gcount[0];
        left[0] = 1;
        left[3] = 1;
        rd_info_rdy_in = 1'b0;
        drive_engines();
        exp3 = make_req(3, seq[3]);
        sample();
        check("t3_grant", 64'(eng_rd_info_rdy_out), 64'h8);
        advance();
        for (int i = 0; i < 5; i++) begin
            sample();
            check("t3_valid", 64'(rd_info_valid_out), 64'd1);
            check("t3_id", 64'(rd_id_out), 64'(exp3.id));
            check("t3_addr", 64'(rd_addr_out), 64'(exp3.addr));
            check("t3_len", 64'(rd_len_out), 64'(exp3.len));
            check("t3_no_rdy", 64'(eng_rd_info_rdy_out), 64'd0);
            advance();
        end
        rd_info_rdy_in = 1'b1;
        wait_idle("t3");
        check("t3_e0_served", 64'(gcount[0] - b0), 64'd1);

        // Beat routing with engine back-pressure.
        set_beat(8'h2A, 4'b0000);
        sample();
        check("t4_valid", 64'(eng_rd_data_valid_out), 64'h4);
        check("t4_rdy_low", 64'(rd_data_rdy_out), 64'd0);
        advance();
        eng_rd_data_rdy_in = 4'b0100;
        sample();
        check("t4_rdy_high", 64'(rd_data_rdy_out), 64'd1);
        check("t4_valid_hold", 64'(eng_rd_data_valid_out), 64'h4);
        check("t4_data_lo", eng_rd_data_out[63:0], rd_data_in[63:0]);
        check("t4_data_hi", eng_rd_data_out[255:192], rd_data_in[255:192]);
        advance();
        clear_beat();

        // Beat for a nonexistent engine.
        set_beat(8'h5C, 4'b0000);
        sample();
        check("t5_rdy", 64'(rd_data_rdy_out), 64'd1);
        check("t5_no_valid", 64'(eng_rd_data_valid_out), 64'd0);
        check("t5_bad_before", 64'(bad_id_out), 64'd0);
        advance();
        clear_beat();
        repeat (3) tick();
        check("t5_bad_sticky", 64'(bad_id_out), 64'd1);

        // Reset during REQ with engine 0 holding two bursts, then a stale last beat.
        do_reset();
        check("t6_bad_cleared", 64'(bad_id_out), 64'd0);
        check("t6_perf_reset", 64'(perf_cnt_out), 64'd0);
        left[0] = 2;
        rd_info_rdy_in = 1'b1;
        drive_engines();
        wait_idle("t6a");
        rd_info_rdy_in = 1'b0;
        left[0] = 1;
        drive_engines();
        tick();
        tick();
        check("t6_in_req", 64'(rd_info_valid_out), 64'd1);
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        req_q.delete();
        for (int e = 0; e < NE; e++) hs_count[e] = 0;
        sample();
        check("t6_valid_cleared", 64'(rd_info_valid_out), 64'd0);
        check("t6_perf_cleared", 64'(perf_cnt_out), 64'd0);
        advance();
        set_beat(8'h00, 4'b0001);
        sample();
        check("t6_stale_valid", 64'(eng_rd_data_valid_out), 64'h1);
        check("t6_stale_rdy", 64'(rd_data_rdy_out), 64'd1);
        advance();
        clear_beat();
        rd_info_rdy_in = 1'b1;
        b0 = gcount[0];
        left[0] = 5;
        drive_engines();
        repeat (14) tick();
        check("t6_full_credit", 64'(gcount[0] - b0), 64'd4);
        check("t6_blocked_idle", 64'(rd_info_valid_out), 64'd0);
`ifdef READ_ARB_PERF_EN
        exp_perf = 64'(hs_count[0]);
`else
        exp_perf = 64'd0;
`endif
        check("t6_perf_count", 64'(perf_cnt_out), exp_perf);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
